full_adder_unit: RTL and testbench
==================================

Name: full_adder_unit

Overview:
Registered full adder, WIDTH bits wide, built as a ripple chain of 1-bit full-adder cells. Computes {c, s} = a + b + cin. The output stage is registered, with a valid flag. The default WIDTH=1 is the single-bit full adder used in the combinational-circuits library. Wider instances serve as small datapath adders.

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range 1..64.
- OUT_REG, 1, 1 = registered outputs (1-cycle latency); 0 = combinational outputs (0 latency), with out_valid = in_valid.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle
- a  input  WIDTH  addend A, unsigned
- b  input  WIDTH  addend B, unsigned
- cin  input  1  carry-in into bit 0
- c  output  1  carry-out from bit WIDTH-1
- s  output  WIDTH  sum bits
- out_valid  output  1  c/s hold a fresh result

Behaviour:
- Per-bit cell, bit i:
  - s[i] = a[i] ^ b[i] ^ k[i]
  - k[i+1] = (a[i] & b[i]) | (k[i] & (a[i] ^ b[i]))
  - k[0] = cin; c = k[WIDTH].
- Arithmetic: unsigned, modulo 2^(WIDTH+1) across {c, s}. There is no overflow flag; c is the overflow indication.
- OUT_REG=1:
  - On a rising clk edge with in_valid=1: the s and c registers load the combinational result, and out_valid <= 1.
  - On a rising clk edge with in_valid=0: s and c hold their previous values, and out_valid <= 0.
  - Latency is exactly 1 cycle. A new operand set can be accepted every cycle. There is no backpressure.
- OUT_REG=0:
  - s and c follow the inputs combinationally; out_valid = in_valid.
  - rst_n forces out_valid=0 only; s and c still track the inputs.
- Reset (rst_n=0, asynchronous assert, synchronous-to-clk deassert assumed by the system):
  - s = 0, c = 0, out_valid = 0 immediately, without waiting for a clock edge.
  - Reset asserted mid-stream discards any in-flight result.
  - The first in_valid accepted is on the first rising edge with rst_n=1.
- X-free: with all inputs known, every output is known in every cycle after reset.
- Boundary cases:
  - All-ones operands with cin=1 give s = all-ones and c=1.
  - All-zeros operands with cin=0 give s=0 and c=0.
  - cin alone propagates through the full ripple chain, e.g. a = all-ones, b=0, cin=1 gives s=0, c=1.

Decomposition:
- Shared package adder_pkg: localparam MAX_WIDTH=64.
- One sub-module, full_adder_bit (ports a, b, ci, s, co; purely combinational). It is instantiated WIDTH times by a generate loop.
- The top level holds the carry chain wire, the output registers and the valid flop.

Test Plan:
- WIDTH=1, OUT_REG=1: drive all 8 {a,b,cin} combos 000..111 with in_valid=1, one per cycle. One cycle later {c,s} must read 00, 01, 01, 10, 01, 10, 10, 11 in that order, with out_valid=1 each time.
- Reset: drive a=1, b=1, cin=1 and clock once so c=1, s=1. Then pull rst_n=0 between edges. c, s and out_valid must drop to 0 with no clock edge, and stay 0 until rst_n=1 and the next valid edge.
- Hold: load a=1, b=0, cin=0, giving s=1, c=0. Then set in_valid=0 and change a, b, cin for 3 cycles. s=1 and c=0 must hold, with out_valid=0.
- WIDTH=8 carry propagation: a=0xFF, b=0x00, cin=1 -> s=0x00, c=1. Then a=0xFF, b=0xFF, cin=1 -> s=0xFF, c=1. Then a=0x5A, b=0x25, cin=0 -> s=0x7F, c=0.
- OUT_REG=0, WIDTH=1: a=0, b=1, cin=1 -> c=1, s=0 in the same cycle, with out_valid equal to in_valid.
- Back-to-back throughput: WIDTH=4 with in_valid=1 every cycle for 16 random operand sets. Each result must match a + b + cin, with exactly 1-cycle latency and no gaps in out_valid.

Source files
------------

// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared constants and helpers for the ripple-carry adder slice.
//
// Contents:
//   MAX_WIDTH     - widest operand the adder is meant to be built at
//   width_legal() - true when a WIDTH value lies in 1..MAX_WIDTH
//   full_sum()    - reference {carry, sum} of one bit position
// -----------------------------------------------------------------------------
package adder_pkg;

  localparam int MAX_WIDTH = 64;

  function automatic bit width_legal(input int width);
    return (width >= 1) && (width <= MAX_WIDTH);
  endfunction

  // Returns {carry_out, sum} for a single bit position. Handy for anyone
  // building a different cell arrangement on top of this package.
  function automatic logic [1:0] full_sum(input logic a, input logic b,
                                          input logic ci);
    return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// -----------------------------------------------------------------------------
// full_adder_bit
// One purely combinational full-adder cell, the building block of the ripple
// chain in full_adder_unit.
//
// Ports:
//   a, b  in   1  operand bits
//   ci    in   1  carry-in from the next lower bit
//   s     out  1  sum bit
//   co    out  1  carry-out to the next higher bit
// -----------------------------------------------------------------------------
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic half_sum;

  // The half-sum is shared: it forms the sum bit and decides whether an
  // incoming carry is propagated.
  assign half_sum = a ^ b;
  assign s        = half_sum ^ ci;
  assign co       = (a & b) | (ci & half_sum);

endmodule

// File: rtl/full_adder_unit.sv
// -----------------------------------------------------------------------------
// full_adder_unit
// WIDTH-bit unsigned adder built from a ripple chain of full_adder_bit cells,
// computing {c, s} = a + b + cin. With OUT_REG=1 the result is registered
// (one cycle latency, one operand set per cycle, no backpressure); with
// OUT_REG=0 the result is combinational and out_valid mirrors in_valid.
//
// Parameters:
//   WIDTH    operand and sum width, 1..64
//   OUT_REG  1 = registered outputs, 0 = combinational outputs
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands valid this cycle
//   a, b       in   WIDTH  unsigned addends
//   cin        in   1      carry into bit 0
//   c          out  1      carry out of bit WIDTH-1
//   s          out  WIDTH  sum bits
//   out_valid  out  1      c/s hold a fresh result
// -----------------------------------------------------------------------------
module full_adder_unit
  import adder_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter bit OUT_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             c,
  output logic [WIDTH-1:0] s,
  output logic             out_valid
);

  // carry[i] is the carry into bit i; carry[WIDTH] is the final carry-out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  assign carry[0] = cin;

  // Ripple chain: each cell consumes the carry of the cell below it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_bit u_bit (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (sum_comb[i]),
      .co (carry[i+1])
    );
  end

  if (OUT_REG) begin : g_reg
    logic [WIDTH-1:0] s_q;
    logic             c_q;
    logic             valid_q;

    // Result registers only load on accepted operands so the last result
    // stays visible during idle cycles; reset clears them immediately.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q <= '0;
        c_q <= 1'b0;
      end else if (in_valid) begin
        s_q <= sum_comb;
        c_q <= carry[WIDTH];
      end
    end

    // The valid flag marks only the cycle directly after an accepted input.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= in_valid;
      end
    end

    assign s         = s_q;
    assign c         = c_q;
    assign out_valid = valid_q;
  end else begin : g_comb
    // Without registers the clock has no job; it is kept on the port list so
    // both variants share one interface.
    logic unused_clk;
    assign unused_clk = clk;

    // Reset only gates the valid flag; the data path keeps tracking inputs.
    assign s         = sum_comb;
    assign c         = carry[WIDTH];
    assign out_valid = in_valid & rst_n;
  end

endmodule

// File: tb/tb_full_adder_unit.sv
// -----------------------------------------------------------------------------
// tb_full_adder_unit
// Directed bench for full_adder_unit covering four configurations:
//   W1 registered, W8 registered, W1 combinational, W4 registered.
// -----------------------------------------------------------------------------
module tb_full_adder_unit;

  logic clk;
  logic rst_n;

  int pass_count;
  int check_count;

  // W1 registered
  logic       w1r_valid, w1r_a, w1r_b, w1r_cin;
  logic       w1r_c, w1r_s, w1r_ov;
  // W8 registered
  logic       w8_valid, w8_cin;
  logic [7:0] w8_a, w8_b;
  logic       w8_c, w8_ov;
  logic [7:0] w8_s;
  // W1 combinational
  logic       w1c_valid, w1c_a, w1c_b, w1c_cin;
  logic       w1c_c, w1c_s, w1c_ov;
  // W4 registered
  logic       w4_valid, w4_cin;
  logic [3:0] w4_a, w4_b;
  logic       w4_c, w4_ov;
  logic [3:0] w4_s;

  full_adder_unit #(.WIDTH(1), .OUT_REG(1'b1)) u_w1r (
    .clk(clk), .rst_n(rst_n), .in_valid(w1r_valid), .a(w1r_a), .b(w1r_b),
    .cin(w1r_cin), .c(w1r_c), .s(w1r_s), .out_valid(w1r_ov)
  );

  full_adder_unit #(.WIDTH(8), .OUT_REG(1'b1)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(w8_valid), .a(w8_a), .b(w8_b),
    .cin(w8_cin), .c(w8_c), .s(w8_s), .out_valid(w8_ov)
  );

  full_adder_unit #(.WIDTH(1), .OUT_REG(1'b0)) u_w1c (
    .clk(clk), .rst_n(rst_n), .in_valid(w1c_valid), .a(w1c_a), .b(w1c_b),
    .cin(w1c_cin), .c(w1c_c), .s(w1c_s), .out_valid(w1c_ov)
  );

  full_adder_unit #(.WIDTH(4), .OUT_REG(1'b1)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(w4_valid), .a(w4_a), .b(w4_b),
    .cin(w4_cin), .c(w4_c), .s(w4_s), .out_valid(w4_ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset state of every instance, then release reset between edges.
  task automatic test_reset_state();
    rst_n = 1'b0;
    {w1r_valid, w1r_a, w1r_b, w1r_cin} = '0;
    {w8_valid, w8_a, w8_b, w8_cin}     = '0;
    {w1c_valid, w1c_a, w1c_b, w1c_cin} = '0;
    {w4_valid, w4_a, w4_b, w4_cin}     = '0;
    repeat (2) @(negedge clk);
    check_count++;
    if ({w1r_ov, w1r_c, w1r_s} !== 3'b000)
      $display("[TB] FAIL reset_w1r got=%b want=000", {w1r_ov, w1r_c, w1r_s});
    else pass_count++;
    check_count++;
    if ({w8_ov, w8_c, w8_s} !== 10'h000)
      $display("[TB] FAIL reset_w8 got=%h want=000", {w8_ov, w8_c, w8_s});
    else pass_count++;
    check_count++;
    if ({w4_ov, w4_c, w4_s} !== 6'b000000)
      $display("[TB] FAIL reset_w4 got=%b want=000000", {w4_ov, w4_c, w4_s});
    else pass_count++;
    check_count++;
    if (w1c_ov !== 1'b0)
      $display("[TB] FAIL reset_w1c_valid got=%b want=0", w1c_ov);
    else pass_count++;
    rst_n = 1'b1;
  endtask

  // All eight single-bit input combinations, one per cycle.
  task automatic test_truth_table();
    logic [1:0] exp_cs [8];
    exp_cs = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    @(negedge clk);
    w1r_valid = 1'b1;
    {w1r_a, w1r_b, w1r_cin} = 3'd0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_count++;
      if ({w1r_ov, w1r_c, w1r_s} !== {1'b1, exp_cs[i]})
        $display("[TB] FAIL truth_%0d got=%b want=%b", i,
                 {w1r_ov, w1r_c, w1r_s}, {1'b1, exp_cs[i]});
      else pass_count++;
      if (i < 7) {w1r_a, w1r_b, w1r_cin} = 3'(i + 1);
      else w1r_valid = 1'b0;
    end
  endtask

  // Reset asserted between edges clears outputs without a clock.
  task automatic test_reset_midstream();
    w1r_valid = 1'b1;
    {w1r_a, w1r_b, w1r_cin} = 3'b111;
    @(negedge clk);
    check_count++;
    if ({w1r_ov, w1r_c, w1r_s} !== 3'b111)
      $display("[TB] FAIL rst_preload got=%b want=111", {w1r_ov, w1r_c, w1r_s});
    else pass_count++;
    #2 rst_n = 1'b0;
    #1;
    check_count++;
    if ({w1r_ov, w1r_c, w1r_s} !== 3'b000)
      $display("[TB] FAIL rst_async got=%b want=000", {w1r_ov, w1r_c, w1r_s});
    else pass_count++;
    @(negedge clk);
    check_count++;
    if ({w1r_ov, w1r_c, w1r_s} !== 3'b000)
      $display("[TB] FAIL rst_held got=%b want=000", {w1r_ov, w1r_c, w1r_s});
    else pass_count++;
    rst_n = 1'b1;
    #1;
    check_count++;
    if ({w1r_ov, w1r_c, w1r_s} !== 3'b000)
      $display("[TB] FAIL rst_release got=%b want=000", {w1r_ov, w1r_c, w1r_s});
    else pass_count++;
    @(negedge clk);
    check_count++;
    if ({w1r_ov, w1r_c, w1r_s} !== 3'b111)
      $display("[TB] FAIL rst_first_edge got=%b want=111", {w1r_ov, w1r_c, w1r_s});
    else pass_count++;
    w1r_valid = 1'b0;
  endtask

  // Idle cycles keep the last result while inputs wander.
  task automatic test_hold();
    logic [2:0] junk [3];
    junk = '{3'b111, 3'b011, 3'b110};
    w1r_valid = 1'b1;
    {w1r_a, w1r_b, w1r_cin} = 3'b100;
    @(negedge clk);
    check_count++;
    if ({w1r_ov, w1r_c, w1r_s} !== 3'b101)
      $display("[TB] FAIL hold_load got=%b want=101", {w1r_ov, w1r_c, w1r_s});
    else pass_count++;
    for (int i = 0; i < 3; i++) begin
      w1r_valid = 1'b0;
      {w1r_a, w1r_b, w1r_cin} = junk[i];
      @(negedge clk);
      check_count++;
      if ({w1r_ov, w1r_c, w1r_s} !== 3'b001)
        $display("[TB] FAIL hold_%0d got=%b want=001", i, {w1r_ov, w1r_c, w1r_s});
      else pass_count++;
    end
  endtask

  // Eight-bit carry propagation and zero boundary.
  task automatic test_carry_w8();
    logic [16:0] vec [4];
    logic [8:0]  exp_cs [4];
    vec    = '{{8'hFF, 8'h00, 1'b1}, {8'hFF, 8'hFF, 1'b1},
               {8'h5A, 8'h25, 1'b0}, {8'h00, 8'h00, 1'b0}};
    exp_cs = '{{1'b1, 8'h00}, {1'b1, 8'hFF}, {1'b0, 8'h7F}, {1'b0, 8'h00}};
    w8_valid = 1'b1;
    {w8_a, w8_b, w8_cin} = vec[0];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_count++;
      if ({w8_ov, w8_c, w8_s} !== {1'b1, exp_cs[i]})
        $display("[TB] FAIL carry_w8_%0d got=%h want=%h", i,
                 {w8_ov, w8_c, w8_s}, {1'b1, exp_cs[i]});
      else pass_count++;
      if (i < 3) {w8_a, w8_b, w8_cin} = vec[i + 1];
      else w8_valid = 1'b0;
    end
  endtask

  // Combinational variant: same-cycle result, reset gates only the flag.
  task automatic test_comb();
    @(negedge clk);
    w1c_valid = 1'b1;
    {w1c_a, w1c_b, w1c_cin} = 3'b011;
    #1;
    check_count++;
    if ({w1c_ov, w1c_c, w1c_s} !== 3'b110)
      $display("[TB] FAIL comb_valid got=%b want=110", {w1c_ov, w1c_c, w1c_s});
    else pass_count++;
    w1c_valid = 1'b0;
    #1;
    check_count++;
    if ({w1c_ov, w1c_c, w1c_s} !== 3'b010)
      $display("[TB] FAIL comb_idle got=%b want=010", {w1c_ov, w1c_c, w1c_s});
    else pass_count++;
    w1c_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check_count++;
    if ({w1c_ov, w1c_c, w1c_s} !== 3'b010)
      $display("[TB] FAIL comb_rst got=%b want=010", {w1c_ov, w1c_c, w1c_s});
    else pass_count++;
    {w1c_a, w1c_b, w1c_cin} = 3'b100;
    #1;
    check_count++;
    if ({w1c_ov, w1c_c, w1c_s} !== 3'b001)
      $display("[TB] FAIL comb_rst_track got=%b want=001", {w1c_ov, w1c_c, w1c_s});
    else pass_count++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_count++;
    if ({w1c_ov, w1c_c, w1c_s} !== 3'b101)
      $display("[TB] FAIL comb_release got=%b want=101", {w1c_ov, w1c_c, w1c_s});
    else pass_count++;
    w1c_valid = 1'b0;
  endtask

  // Sixteen operand sets on consecutive cycles through the 4-bit adder.
  task automatic test_back_to_back();
    logic [3:0] va [16];
    logic [3:0] vb [16];
    logic       vc [16];
    logic [4:0] want;
    for (int i = 0; i < 16; i++) begin
      va[i] = 4'($urandom_range(0, 15));
      vb[i] = 4'($urandom_range(0, 15));
      vc[i] = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    w4_valid = 1'b1;
    w4_a = va[0]; w4_b = vb[0]; w4_cin = vc[0];
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      want = 5'(va[i]) + 5'(vb[i]) + 5'(vc[i]);
      check_count++;
      if ({w4_ov, w4_c, w4_s} !== {1'b1, want})
        $display("[TB] FAIL b2b_%0d a=%h b=%h cin=%b got=%b want=%b", i,
                 va[i], vb[i], vc[i], {w4_ov, w4_c, w4_s}, {1'b1, want});
      else pass_count++;
      if (i < 15) begin
        w4_a = va[i + 1]; w4_b = vb[i + 1]; w4_cin = vc[i + 1];
      end else begin
        w4_valid = 1'b0;
      end
    end
  endtask

  initial begin
    pass_count  = 0;
    check_count = 0;
    test_reset_state();
    test_truth_table();
    test_reset_midstream();
    test_hold();
    test_carry_w8();
    test_comb();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
